// File: rtl/wait_ram.sv
// wait_ram: byte-enabled single-port RAM with a fixed-latency read pipeline
// and an optional post-reset clearing sweep.
module wait_ram #(
  parameter int D     = 32,
  parameter int A     = 8,
  parameter int LAT   = 1,
  parameter int CLEAR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [A-1:0]   req_addr,
  input  logic [D-1:0]   req_wdata,
  input  logic [D/8-1:0] req_be,
  output logic           rsp_valid,
  output logic [D-1:0]   rsp_rdata,
  output logic           busy
);

  localparam int         NB         = D / 8;
  localparam logic [1:0] LAT_LOAD   = 2'(LAT - 1);
  localparam logic [A:0] SWEEP_LAST = {1'b0, {A{1'b1}}};
  localparam logic [A:0] SWEEP_ONE  = {{A{1'b0}}, 1'b1};
  localparam logic       CLR_EN     = (CLEAR != 32'sd0);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t       state_r;
  logic [A:0]   sweep_r;
  logic [1:0]   lat_r;
  logic         ready_r;
  logic         busy_r;
  logic         rsp_valid_r;
  logic [D-1:0] rdata_r;
  logic [D-1:0] mem_r [2**A];

  logic         clr_we_s;
  logic         wr_we_s;
  logic         rd_acc_s;

  // Decode which array operation (clear, write, read capture) happens this cycle
  always_comb begin
    clr_we_s = 1'b0;
    wr_we_s  = 1'b0;
    rd_acc_s = 1'b0;
    if (state_r == INIT) begin
      clr_we_s = CLR_EN && !sweep_r[A];
    end else if (state_r == IDLE) begin
      wr_we_s  = req_valid && req_we;
      rd_acc_s = req_valid && !req_we;
    end else begin
      clr_we_s = 1'b0;
    end
  end

  // Storage array: never reset, only the INIT sweep zeroes it
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[sweep_r[A-1:0]] <= '0;
    end else if (wr_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      sweep_r     <= '0;
      lat_r       <= '0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b1;
      rsp_valid_r <= 1'b0;
      rdata_r     <= '0;
    end else begin
      case (state_r)
        INIT: begin
          rsp_valid_r <= 1'b0;
          // The last sweep write and the move to IDLE share one edge
          if (!CLR_EN || (sweep_r >= SWEEP_LAST)) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            sweep_r <= sweep_r + SWEEP_ONE;
          end
        end
        IDLE: begin
          if (rd_acc_s) begin
            state_r     <= WAIT;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
            lat_r       <= LAT_LOAD;
            rdata_r     <= mem_r[req_addr];
            rsp_valid_r <= (LAT_LOAD == 2'd0);
          end else begin
            rsp_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (lat_r == 2'd0) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
          end else begin
            lat_r       <= lat_r - 2'd1;
            rsp_valid_r <= (lat_r == 2'd1);
          end
        end
        default: begin
          state_r     <= INIT;
          ready_r     <= 1'b0;
          busy_r      <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;

endmodule

// File: tb/tb_wait_ram.sv
// Scoreboard bench for wait_ram: five instances cover the default, LAT=3,
// LAT=4, LAT=2 (reset-abort) and CLEAR=0 configurations.
module tb_wait_ram;

  localparam int NK = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NK];
  logic        req_valid [NK];
  logic        req_ready [NK];
  logic        req_we    [NK];
  logic [7:0]  req_addr  [NK];
  logic [31:0] req_wdata [NK];
  logic [3:0]  req_be    [NK];
  logic        rsp_valid [NK];
  logic [31:0] rsp_rdata [NK];
  logic        busy      [NK];

  for (genvar g = 0; g < NK; g++) begin : g_dut
    wait_ram #(
      .D     (32),
      .A     (8),
      .LAT   ((g == 1) ? 3 : (g == 2) ? 4 : (g == 3) ? 2 : 1),
      .CLEAR ((g == 4) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q [$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   bcnt [NK];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int k);
    return (k == 1) ? 3 : (k == 2) ? 4 : (k == 3) ? 2 : 1;
  endfunction

  // Monitor: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NK; k++) begin
      if (rsp_valid[k] === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_spurious: dut %0d rsp_valid=1 data=%h at cycle %0d, required no response",
                   k, rsp_rdata[k], cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.k != k || e.data !== rsp_rdata[k] || e.cyc != cyc) begin
            errors++;
            $display("FAIL rsp_data: got dut %0d data %h cycle %0d, required dut %0d data %h cycle %0d",
                     k, rsp_rdata[k], cyc, e.k, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wr(int k, logic [7:0] a, logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
  endtask

  // Response is due in the LAT-th cycle after the accept edge
  task automatic rd(int k, logic [7:0] a, logic [31:0] d, bit expect_rsp);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = a;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    if (expect_rsp) sb_q.push_back('{k, d, cyc + lat_of(k) - 1});
  endtask

  task automatic wait_ready(int k);
    int n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (req_ready[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: dut %0d req_ready=%b after 50 cycles, required 1", k, req_ready[k]);
    end
  endtask

  task automatic count_busy(int n);
    for (int k = 0; k < NK; k++) bcnt[k] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) if (busy[k] === 1'b1) bcnt[k]++;
    end
  endtask

  task automatic pulse_rst(int k);
    @(posedge clk);
    #1 rst_n[k] = 1'b0;
    @(posedge clk);
    #1 rst_n[k] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int k = 0; k < NK; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 8'h00;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
    end

    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk("rst_ready", req_ready[k], 32'd0);
      chk("rst_busy", busy[k], 32'd1);
      chk("rst_rsp_valid", rsp_valid[k], 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) rst_n[k] = 1'b1;

    count_busy(300);
    for (int k = 0; k < NK; k++) chk("busy_cycles", bcnt[k], (k == 4) ? 32'd1 : 32'd256);

    for (int a = 0; a < 256; a++) begin
      wait_ready(0);
      rd(0, 8'(a), 32'h0000_0000, 1'b1);
    end

    // Byte enables
    wait_ready(0);
    wr(0, 8'd9, 32'hAABB_CCDD, 4'b1111);
    wr(0, 8'd9, 32'h1122_3344, 4'b0101);
    rd(0, 8'd9, 32'hAA22_CC44, 1'b1);
    wait_ready(0);
    wr(0, 8'd9, 32'hFFFF_FFFF, 4'b0000);
    rd(0, 8'd9, 32'hAA22_CC44, 1'b1);
    wait_ready(0);

    // Address extremes, then confirm the sweep never resumes
    wr(0, 8'd255, 32'hC0FF_EE01, 4'b1111);
    wr(0, 8'd0, 32'h0BAD_F00D, 4'b1111);
    rd(0, 8'd255, 32'hC0FF_EE01, 1'b1);
    wait_ready(0);
    rd(0, 8'd0, 32'h0BAD_F00D, 1'b1);
    wait_ready(0);
    count_busy(300);
    chk("busy_after_sweep", bcnt[0], 32'd0);
    rd(0, 8'd0, 32'h0BAD_F00D, 1'b1);
    wait_ready(0);

    // LAT=3: write then read on the next cycle
    wait_ready(1);
    wr(1, 8'd5, 32'hDEAD_BEEF, 4'b1111);
    rd(1, 8'd5, 32'hDEAD_BEEF, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("lat3_ready", req_ready[1], (i == 4) ? 32'd1 : 32'd0);
    end

    // LAT=4: held read is re-accepted only after returning to IDLE
    wait_ready(2);
    wr(2, 8'd7, 32'h0F1E_2D3C, 4'b1111);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 8'd7;
    @(posedge clk);
    #1;
    c0 = cyc;
    sb_q.push_back('{2, 32'h0F1E_2D3C, c0 + 3});
    sb_q.push_back('{2, 32'h0F1E_2D3C, c0 + 8});
    repeat (9) @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    chk("lat4_ready_after_hold", req_ready[2], 32'd1);
    rd(2, 8'd7, 32'h0F1E_2D3C, 1'b1);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 8'd7;
    req_wdata[2] = 32'hBAD0_BAD0;
    req_be[2]    = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    req_we[2]    = 1'b0;
    wait_ready(2);
    rd(2, 8'd7, 32'h0F1E_2D3C, 1'b1);
    wait_ready(2);

    // LAT=2: reset one cycle after a read accept kills the response
    wait_ready(3);
    wr(3, 8'd0, 32'h5A5A_5A5A, 4'b1111);
    wr(3, 8'd3, 32'hA5A5_A5A5, 4'b1111);
    rd(3, 8'd3, 32'hA5A5_A5A5, 1'b0);
    rst_n[3] = 1'b0;
    @(posedge clk);
    #1 rst_n[3] = 1'b1;
    count_busy(300);
    chk("abort_busy_cycles", bcnt[3], 32'd256);
    wait_ready(3);
    rd(3, 8'd0, 32'h0000_0000, 1'b1);
    wait_ready(3);
    rd(3, 8'd3, 32'h0000_0000, 1'b1);
    wait_ready(3);

    // Reset in the middle of the sweep restarts it from address 0
    wr(3, 8'd3, 32'hA5A5_A5A5, 4'b1111);
    pulse_rst(3);
    repeat (100) @(posedge clk);
    pulse_rst(3);
    count_busy(300);
    chk("restart_busy_cycles", bcnt[3], 32'd256);
    wait_ready(3);
    rd(3, 8'd3, 32'h0000_0000, 1'b1);
    wait_ready(3);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
